mem_port_arbiter: RTL

- Shares one byte-wide external memory port between the core's instruction-fetch port and its data port.
- Serialises each 32-bit word access into four byte beats; big-endian (lane 0 = MSB, at base address).
- Raises per-port done/err pulses; the core stalls while a request is pending and done is low.
- Sits between mips_core (inst_addr/inst, mem_addr/mem_data_in/mem_data_out/mem_write_en) and the memory model.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  typedef enum logic {
    FETCH,
    DATA
  } port_t;

  typedef logic [7:0] byte_t;

  // Lane 0 is the most significant byte and lives at the base address.
  typedef byte_t [0:3] word_lanes_t;

  localparam int BEATS_PER_WORD = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever port was not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_fetch_i,
  input  logic  req_data_i,
  input  logic  grant_en_i,
  output port_t grant_o
);

  port_t last_q;

  // Pick the winner from the current requests and the last grant.
  always_comb begin
    grant_o = FETCH;
    if (req_fetch_i && req_data_i) begin
      grant_o = (last_q == FETCH) ? DATA : FETCH;
    end else if (req_data_i) begin
      grant_o = DATA;
    end
  end

  // Remember who was served; reset value makes data win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= FETCH;
    end else if (grant_en_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and data
// accesses, splitting each 32-bit word into four big-endian byte beats.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  byte_t             d_wdata [0:3],
  output byte_t             d_rdata [0:3],
  output logic              d_done,
  output logic              d_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]        LAST_BEAT = 2'(BEATS_PER_WORD - 1);

  state_t              state_q, state_d;
  port_t               port_q, port_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  word_lanes_t         lanes_q, lanes_d;
  word_lanes_t         i_rdata_q, i_rdata_d;
  word_lanes_t         d_rdata_q, d_rdata_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]          bus_wdata_q, bus_wdata_d;

  port_t               grant;
  logic                grant_en;
  logic                xfer_end;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic [1:0]          next_beat;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst_b),
    .req_fetch_i (i_req),
    .req_data_i  (d_req),
    .grant_en_i  (grant_en),
    .grant_o     (grant)
  );

  // Next-state logic: grant in IDLE, sequence beats in XFER, pulse in DONE.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    err_d       = err_q;
    base_d      = base_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    lanes_d     = lanes_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    grant_en    = 1'b0;
    xfer_end    = 1'b0;
    sel_addr    = (grant == DATA) ? d_addr : i_addr;
    sel_we      = (grant == DATA) && d_we;
    next_beat   = beat_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_en = 1'b1;
          port_d   = grant;
          if (sel_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d  = 1'b0;
            base_d = sel_addr;
            we_d   = sel_we;
            beat_d = '0;
            wait_d = '0;
            // Reads start from the port's current word so that lanes never
            // reached (timeout) keep their previous value.
            if (sel_we) begin
              lanes_d = {d_wdata[0], d_wdata[1], d_wdata[2], d_wdata[3]};
            end else if (grant == DATA) begin
              lanes_d = d_rdata_q;
            end else begin
              lanes_d = i_rdata_q;
            end
            bus_req_d   = 1'b1;
            bus_we_d    = sel_we;
            bus_addr_d  = sel_addr;
            bus_wdata_d = sel_we ? d_wdata[0] : 8'h00;
            state_d     = XFER;
          end
        end
      end
      XFER: begin
        if (bus_ack) begin
          wait_d = '0;
          if (!we_q) begin
            lanes_d[beat_q] = bus_rdata;
          end
          if (beat_q == LAST_BEAT) begin
            err_d    = 1'b0;
            xfer_end = 1'b1;
            state_d  = DONE;
          end else begin
            beat_d      = next_beat;
            bus_addr_d  = base_q + ADDR_W'(next_beat);
            bus_wdata_d = we_q ? lanes_q[next_beat] : 8'h00;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d    = 1'b1;
          xfer_end = 1'b1;
          state_d  = DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (xfer_end) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_wdata_d = 8'h00;
      if (!we_q) begin
        if (port_q == DATA) begin
          d_rdata_d = lanes_d;
        end else begin
          i_rdata_d = lanes_d;
        end
      end
    end
  end

  // State and registered bus outputs; reset drops bus_req immediately.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q     <= IDLE;
      port_q      <= FETCH;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      lanes_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      err_q       <= err_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      lanes_q     <= lanes_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign i_done    = (state_q == DONE) && (port_q == FETCH);
  assign i_err     = i_done && err_q;
  assign d_done    = (state_q == DONE) && (port_q == DATA);
  assign d_err     = d_done && err_q;
  assign i_rdata   = i_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  for (genvar k = 0; k < BEATS_PER_WORD; k++) begin : g_d_rdata
    assign d_rdata[k] = d_rdata_q[k];
  end

endmodule
